// File: rtl/alu_pkg.sv
// Shared ALU definitions: command encodings and default widths used by the
// issue pipe and anything that attaches an ALU to it.
package alu_pkg;

    localparam int CMD_W         = 3;
    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [CMD_W-1:0] {
        CMD_ADD  = 3'd0,
        CMD_SUB  = 3'd1,
        CMD_XOR  = 3'd2,
        CMD_SLT  = 3'd3,
        CMD_AND  = 3'd4,
        CMD_NAND = 3'd5,
        CMD_NOR  = 3'd6,
        CMD_OR   = 3'd7
    } alu_cmd_e;

endpackage

// File: rtl/alu_pipe_reg.sv
// Generic valid+payload pipeline register with load, valid-clear and hold.
// A load takes priority over a clear; the payload is left stale on a clear.
module alu_pipe_reg #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_load,
    input  logic          i_validIn,
    input  logic          i_clear,
    input  logic [PW-1:0] i_data,
    output logic          o_valid,
    output logic [PW-1:0] o_data
);

    logic          r_valid;
    logic [PW-1:0] r_data;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= i_validIn;
            r_data  <= i_data;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/alu_issue_pipe.sv
// Two-stage issue/capture pipe around an external combinational ALU:
// stage A holds the request driving the ALU, stage B holds the captured result.
module alu_issue_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_operandA,
    input  logic [WIDTH-1:0] in_operandB,
    input  logic [CMD_W-1:0] in_command,
    output logic [WIDTH-1:0] alu_operandA,
    output logic [WIDTH-1:0] alu_operandB,
    output logic [CMD_W-1:0] alu_command,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carryout,
    output logic             out_zero,
    output logic             out_overflow,
    output logic [CMD_W-1:0] out_command,
    output logic [CNT_W-1:0] op_count
);

    localparam int PW_A = CMD_W + 2 * WIDTH;
    localparam int PW_B = CMD_W + 3 + WIDTH;

    logic            w_validA;
    logic            w_validB;
    logic            w_advA;
    logic            w_advB;
    logic            w_accept;
    logic [PW_A-1:0] w_dataAIn;
    logic [PW_A-1:0] w_dataA;
    logic [PW_B-1:0] w_dataBIn;
    logic [PW_B-1:0] w_dataB;
    logic [CNT_W-1:0] r_opCount;

    assign w_advB   = !w_validB || out_ready;
    assign w_advA   = w_validA && w_advB;
    assign in_ready = reset_n && (!w_validA || w_advB);
    assign w_accept = in_valid && in_ready;

    assign w_dataAIn = {in_command, in_operandA, in_operandB};

    // Stage A: a new request loads; otherwise it empties when its op moves on.
    alu_pipe_reg #(.PW(PW_A)) u_stageA (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_load    (w_accept),
        .i_validIn (1'b1),
        .i_clear   (w_advA),
        .i_data    (w_dataAIn),
        .o_valid   (w_validA),
        .o_data    (w_dataA)
    );

    assign alu_command  = w_dataA[PW_A-1 -: CMD_W];
    assign alu_operandA = w_dataA[2*WIDTH-1 -: WIDTH];
    assign alu_operandB = w_dataA[WIDTH-1:0];

    assign w_dataBIn = {alu_command, alu_carryout, alu_zero, alu_overflow, alu_result};

    // Stage B captures whatever the ALU shows whenever it may advance; the
    // valid bit tells whether that capture was a real op.
    alu_pipe_reg #(.PW(PW_B)) u_stageB (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_load    (w_advB),
        .i_validIn (w_validA),
        .i_clear   (1'b0),
        .i_data    (w_dataBIn),
        .o_valid   (w_validB),
        .o_data    (w_dataB)
    );

    assign out_valid    = w_validB;
    assign out_command  = w_dataB[PW_B-1 -: CMD_W];
    assign out_carryout = w_dataB[WIDTH+2];
    assign out_zero     = w_dataB[WIDTH+1];
    assign out_overflow = w_dataB[WIDTH];
    assign out_result   = w_dataB[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_opCount <= '0;
        end else if (w_validB && out_ready) begin
            r_opCount <= r_opCount + CNT_W'(1);
        end
    end

    assign op_count = r_opCount;

endmodule

// File: tb/tb_alu_issue_pipe.sv
// Directed bench for alu_issue_pipe with a small behavioural ALU attached;
// expected values are hand-computed constants.
module tb_alu_issue_pipe;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_operandA;
    logic [WIDTH-1:0] in_operandB;
    logic [2:0]       in_command;
    logic [WIDTH-1:0] alu_operandA;
    logic [WIDTH-1:0] alu_operandB;
    logic [2:0]       alu_command;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carryout;
    logic             alu_zero;
    logic             alu_overflow;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carryout;
    logic             out_zero;
    logic             out_overflow;
    logic [2:0]       out_command;
    logic [CNT_W-1:0] op_count;

    int compareCount;
    int mismatchCount;

    alu_issue_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_operandA  (in_operandA),
        .in_operandB  (in_operandB),
        .in_command   (in_command),
        .alu_operandA (alu_operandA),
        .alu_operandB (alu_operandB),
        .alu_command  (alu_command),
        .alu_result   (alu_result),
        .alu_carryout (alu_carryout),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_carryout (out_carryout),
        .out_zero     (out_zero),
        .out_overflow (out_overflow),
        .out_command  (out_command),
        .op_count     (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the external ALU.
    always_comb begin
        logic [WIDTH:0] sum;
        sum          = '0;
        alu_result   = '0;
        alu_carryout = 1'b0;
        alu_overflow = 1'b0;
        case (alu_command)
            CMD_ADD: begin
                sum          = {1'b0, alu_operandA} + {1'b0, alu_operandB};
                alu_result   = sum[WIDTH-1:0];
                alu_carryout = sum[WIDTH];
                alu_overflow = (alu_operandA[WIDTH-1] == alu_operandB[WIDTH-1]) &&
                               (sum[WIDTH-1] != alu_operandA[WIDTH-1]);
            end
            CMD_SUB: begin
                sum          = {1'b0, alu_operandA} + {1'b0, ~alu_operandB} + 33'd1;
                alu_result   = sum[WIDTH-1:0];
                alu_carryout = sum[WIDTH];
                alu_overflow = (alu_operandA[WIDTH-1] != alu_operandB[WIDTH-1]) &&
                               (sum[WIDTH-1] != alu_operandA[WIDTH-1]);
            end
            CMD_XOR:  alu_result = alu_operandA ^ alu_operandB;
            CMD_SLT:  alu_result = {31'd0, $signed(alu_operandA) < $signed(alu_operandB)};
            CMD_AND:  alu_result = alu_operandA & alu_operandB;
            CMD_NAND: alu_result = ~(alu_operandA & alu_operandB);
            CMD_NOR:  alu_result = ~(alu_operandA | alu_operandB);
            default:  alu_result = alu_operandA | alu_operandB;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] cmd, input logic rdy);
        in_valid    = v;
        in_operandA = a;
        in_operandB = b;
        in_command  = cmd;
        out_ready   = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] expResult;

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        reset_n       = 1'b0;
        applyStimulus(1'b0, '0, '0, 3'd0, 1'b0);

        // Reset for two cycles
        tick();
        checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        checkOutput("rst_in_ready2", {63'd0, in_ready}, 64'd0);
        checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_op_count", {48'd0, op_count}, 64'd0);
        checkOutput("rst_out_result", {32'd0, out_result}, 64'd0);
        checkOutput("rst_out_command", {61'd0, out_command}, 64'd0);
        checkOutput("rst_out_flags", {61'd0, out_carryout, out_zero, out_overflow}, 64'd0);
        checkOutput("rst_alu_opA", {32'd0, alu_operandA}, 64'd0);
        reset_n = 1'b1;
        #1;
        checkOutput("rel_in_ready", {63'd0, in_ready}, 64'd1);

        // Single XOR op
        applyStimulus(1'b1, 32'hFFFF0000, 32'h0F0F0F0F, CMD_XOR, 1'b1);
        checkOutput("single_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        applyStimulus(1'b0, '0, '0, 3'd0, 1'b1);
        checkOutput("single_valid_n", {63'd0, out_valid}, 64'd0);
        checkOutput("single_alu_opA", {32'd0, alu_operandA}, 64'hFFFF0000);
        checkOutput("single_alu_cmd", {61'd0, alu_command}, 64'd2);
        tick();
        checkOutput("single_valid_n1", {63'd0, out_valid}, 64'd1);
        checkOutput("single_result", {32'd0, out_result}, 64'hF0F00F0F);
        checkOutput("single_command", {61'd0, out_command}, 64'd2);
        checkOutput("single_zero", {63'd0, out_zero}, 64'd0);
        checkOutput("single_cnt_pre", {48'd0, op_count}, 64'd0);
        tick();
        checkOutput("single_cnt", {48'd0, op_count}, 64'd1);
        checkOutput("single_drained", {63'd0, out_valid}, 64'd0);

        // Streaming 8 back-to-back XOR ops
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 32'(i), 32'hFFFFFFFF, CMD_XOR, 1'b1);
            checkOutput("stream_in_ready", {63'd0, in_ready}, 64'd1);
            tick();
            if (i >= 1) begin
                expResult = 32'hFFFFFFFF - 32'(i - 1);
                checkOutput("stream_valid", {63'd0, out_valid}, 64'd1);
                checkOutput("stream_result", {32'd0, out_result}, {32'd0, expResult});
            end
        end
        applyStimulus(1'b0, '0, '0, 3'd0, 1'b1);
        tick();
        checkOutput("stream_last", {32'd0, out_result}, 64'hFFFFFFF8);
        tick();
        checkOutput("stream_cnt", {48'd0, op_count}, 64'd9);
        checkOutput("stream_empty", {63'd0, out_valid}, 64'd0);

        // Backpressure: fill both stages, stall five cycles
        applyStimulus(1'b1, 32'h11, 32'h22, CMD_ADD, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h5, 32'h3, CMD_SUB, 1'b0);
        checkOutput("bp_fill_ready", {63'd0, in_ready}, 64'd1);
        tick();
        applyStimulus(1'b1, 32'h99, 32'h99, CMD_OR, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_in_ready", {63'd0, in_ready}, 64'd0);
            checkOutput("bp_valid", {63'd0, out_valid}, 64'd1);
            checkOutput("bp_result", {32'd0, out_result}, 64'h33);
            checkOutput("bp_command", {61'd0, out_command}, 64'd0);
            checkOutput("bp_alu_opA", {32'd0, alu_operandA}, 64'h5);
            checkOutput("bp_cnt", {48'd0, op_count}, 64'd9);
            tick();
        end
        applyStimulus(1'b0, '0, '0, 3'd0, 1'b1);
        checkOutput("bp_rel_ready", {63'd0, in_ready}, 64'd1);
        tick();
        checkOutput("bp_drain1_valid", {63'd0, out_valid}, 64'd1);
        checkOutput("bp_drain1_result", {32'd0, out_result}, 64'h2);
        checkOutput("bp_drain1_cmd", {61'd0, out_command}, 64'd1);
        checkOutput("bp_drain1_carry", {63'd0, out_carryout}, 64'd1);
        checkOutput("bp_drain1_cnt", {48'd0, op_count}, 64'd10);
        tick();
        checkOutput("bp_drain2_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("bp_drain2_cnt", {48'd0, op_count}, 64'd11);

        // Simultaneous drain/advance/accept with both stages full
        applyStimulus(1'b1, 32'hFFFFFFFF, 32'h1, CMD_ADD, 1'b0);
        tick();
        applyStimulus(1'b1, 32'hF0, 32'hFF, CMD_AND, 1'b0);
        tick();
        checkOutput("sim_full_result", {32'd0, out_result}, 64'h0);
        checkOutput("sim_full_flags", {61'd0, out_carryout, out_zero, out_overflow}, 64'b110);
        applyStimulus(1'b1, 32'h10, 32'h10, CMD_XOR, 1'b1);
        checkOutput("sim_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        applyStimulus(1'b0, '0, '0, 3'd0, 1'b1);
        checkOutput("sim_valid", {63'd0, out_valid}, 64'd1);
        checkOutput("sim_result", {32'd0, out_result}, 64'hF0);
        checkOutput("sim_command", {61'd0, out_command}, 64'd4);
        checkOutput("sim_alu_opA", {32'd0, alu_operandA}, 64'h10);
        checkOutput("sim_alu_cmd", {61'd0, alu_command}, 64'd2);
        checkOutput("sim_cnt", {48'd0, op_count}, 64'd12);
        tick();
        checkOutput("sim_next_result", {32'd0, out_result}, 64'h0);
        checkOutput("sim_next_flags", {61'd0, out_carryout, out_zero, out_overflow}, 64'b010);
        checkOutput("sim_next_cnt", {48'd0, op_count}, 64'd13);
        tick();
        checkOutput("sim_empty", {63'd0, out_valid}, 64'd0);
        checkOutput("sim_end_cnt", {48'd0, op_count}, 64'd14);

        // Mid-operation reset with both stages valid
        applyStimulus(1'b1, 32'h1, 32'h2, CMD_ADD, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h3, 32'h4, CMD_ADD, 1'b0);
        tick();
        checkOutput("mr_full_valid", {63'd0, out_valid}, 64'd1);
        applyStimulus(1'b0, '0, '0, 3'd0, 1'b0);
        reset_n = 1'b0;
        #1;
        checkOutput("mr_in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        checkOutput("mr_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("mr_cnt", {48'd0, op_count}, 64'd0);
        checkOutput("mr_result", {32'd0, out_result}, 64'd0);
        reset_n = 1'b1;
        applyStimulus(1'b0, '0, '0, 3'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("mr_no_stale", {63'd0, out_valid}, 64'd0);
            checkOutput("mr_cnt_hold", {48'd0, op_count}, 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
